// File: rtl/delay_line_pkg.sv
// Shared types and sizing helpers for the delay-line sweep sequencer.
// Optional min/max statistics are enabled with DELAY_LINE_SWEEP_MINMAX_EN.
package delay_line_pkg;

  localparam int unsigned TAPS_DEF      = 32;
  localparam int unsigned MAXLOG_DEF    = 4;
  localparam int unsigned PRIME_CYC_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EVAL    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Width needed to hold a stage count from 0 up to and including taps.
  function automatic int unsigned calc_tapw(input int unsigned taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/delay_line_therm2bin.sv
// Leading-ones counter: number of consecutive 1s from bit 0 of a tapped thermometer code.
// The first 0 ends the run, so bubbles further up the line never add to the count.
module delay_line_therm2bin
  import delay_line_pkg::*;
#(
  parameter int unsigned TAPS = TAPS_DEF,
  parameter int unsigned TAPW = calc_tapw(TAPS)
) (
  input  logic [TAPS-1:0] taps_i,
  output logic [TAPW-1:0] cnt_o
);

  logic [TAPW-1:0] cnt;
  logic            ones_run;

  // Walk up from the launch end while the run of ones is unbroken.
  always_comb begin
    cnt      = {TAPW{1'b0}};
    ones_run = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      if (ones_run && taps_i[i]) begin
        cnt = cnt + TAPW'(1'b1);
      end else begin
        ones_run = 1'b0;
      end
    end
  end

  assign cnt_o = cnt;

endmodule

// File: rtl/delay_line_sweep_ctrl.sv
// Delay-line sweep sequencer: flush, launch, capture one clk later, count stages, average 2^n shots.
// Define DELAY_LINE_SWEEP_MINMAX_EN to add per-measurement min/max stage-count outputs.
module delay_line_sweep_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned TAPS      = TAPS_DEF,
  parameter int unsigned TAPW      = calc_tapw(TAPS),
  parameter int unsigned MAXLOG    = MAXLOG_DEF,
  parameter int unsigned PRIME_CYC = PRIME_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [2:0]             shots_log2_i,
  output logic                   launch_o,
  input  logic [TAPS-1:0]        taps_i,
  output logic                   busy_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [TAPW-1:0]        res_avg_o,
  output logic [TAPW+MAXLOG-1:0] res_sum_o,
  output logic                   res_sat_o
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
  ,
  output logic [TAPW-1:0]        res_min_o,
  output logic [TAPW-1:0]        res_max_o
`endif
);

  localparam int unsigned SUMW = TAPW + MAXLOG;
  localparam int unsigned PCW  = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;
  localparam logic [PCW-1:0]  PRIME_LAST = PCW'(PRIME_CYC - 1);
  localparam logic [2:0]      MAXLOG_N   = 3'(MAXLOG);
  localparam logic [TAPW-1:0] TAPS_CNT   = TAPW'(TAPS);

  state_e            state_q, state_d;
  logic [PCW-1:0]    prime_q, prime_d;
  logic [MAXLOG-1:0] shot_q, shot_d;
  logic [2:0]        n_q, n_d;
  logic [TAPS-1:0]   taps_q, taps_d;
  logic [SUMW-1:0]   acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              launch_q, launch_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [TAPW-1:0]   res_avg_q, res_avg_d;
  logic [SUMW-1:0]   res_sum_q, res_sum_d;
  logic              res_sat_q, res_sat_d;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
  logic [TAPW-1:0]   min_q, min_d;
  logic [TAPW-1:0]   max_q, max_d;
  logic [TAPW-1:0]   res_min_q, res_min_d;
  logic [TAPW-1:0]   res_max_q, res_max_d;
`endif

  logic [TAPW-1:0]   cnt;
  logic [MAXLOG:0]   last_shot;
  logic [2:0]        n_clamped;

  delay_line_therm2bin #(
    .TAPS (TAPS),
    .TAPW (TAPW)
  ) u_therm2bin (
    .taps_i (taps_q),
    .cnt_o  (cnt)
  );

  assign last_shot = ({{MAXLOG{1'b0}}, 1'b1} << n_q) - {{MAXLOG{1'b0}}, 1'b1};
  assign n_clamped = (shots_log2_i > MAXLOG_N) ? MAXLOG_N : shots_log2_i;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    prime_d   = prime_q;
    shot_d    = shot_q;
    n_d       = n_q;
    taps_d    = taps_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    res_avg_d = res_avg_q;
    res_sum_d = res_sum_q;
    res_sat_d = res_sat_q;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_d     = n_clamped;
          acc_d   = {SUMW{1'b0}};
          shot_d  = {MAXLOG{1'b0}};
          sat_d   = 1'b0;
          prime_d = {PCW{1'b0}};
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
          min_d   = TAPS_CNT;
          max_d   = {TAPW{1'b0}};
`endif
          state_d = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (prime_q == PRIME_LAST) begin
          state_d = ST_LAUNCH;
        end else begin
          prime_d = prime_q + PCW'(1'b1);
        end
      end
      ST_LAUNCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        taps_d  = taps_i;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        acc_d = acc_q + SUMW'(cnt);
        sat_d = sat_q | (cnt == TAPS_CNT);
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
        min_d = (cnt < min_q) ? cnt : min_q;
        max_d = (cnt > max_q) ? cnt : max_q;
`endif
        // Results are latched once so res_* hold after the handshake and across the next run.
        if ({1'b0, shot_q} == last_shot) begin
          res_sum_d = acc_d;
          res_avg_d = TAPW'(acc_d >> n_q);
          res_sat_d = sat_d;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
          res_min_d = min_d;
          res_max_d = max_d;
`endif
          state_d   = ST_DONE;
        end else begin
          shot_d  = shot_q + MAXLOG'(1'b1);
          prime_d = {PCW{1'b0}};
          state_d = ST_PRIME;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    launch_d = (state_d == ST_LAUNCH) || (state_d == ST_CAPTURE) || (state_d == ST_EVAL);
    busy_d   = (state_d != ST_IDLE);
    valid_d  = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prime_q   <= {PCW{1'b0}};
      shot_q    <= {MAXLOG{1'b0}};
      n_q       <= 3'd0;
      taps_q    <= {TAPS{1'b0}};
      acc_q     <= {SUMW{1'b0}};
      sat_q     <= 1'b0;
      launch_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      res_avg_q <= {TAPW{1'b0}};
      res_sum_q <= {SUMW{1'b0}};
      res_sat_q <= 1'b0;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
      min_q     <= {TAPW{1'b0}};
      max_q     <= {TAPW{1'b0}};
      res_min_q <= {TAPW{1'b0}};
      res_max_q <= {TAPW{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      shot_q    <= shot_d;
      n_q       <= n_d;
      taps_q    <= taps_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      res_avg_q <= res_avg_d;
      res_sum_q <= res_sum_d;
      res_sat_q <= res_sat_d;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
`endif
    end
  end

  assign launch_o    = launch_q;
  assign busy_o      = busy_q;
  assign res_valid_o = valid_q;
  assign res_avg_o   = res_avg_q;
  assign res_sum_o   = res_sum_q;
  assign res_sat_o   = res_sat_q;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
  assign res_min_o   = res_min_q;
  assign res_max_o   = res_max_q;
`endif

endmodule

// File: tb/tb_delay_line_sweep_ctrl.sv
// Directed self-checking bench for delay_line_sweep_ctrl (default parameters).
// Min/max checks are active when DELAY_LINE_SWEEP_MINMAX_EN is defined.
module tb_delay_line_sweep_ctrl;

  localparam int TAPS = 32;
  localparam int TAPW = 6;
  localparam int SUMW = 10;
  localparam int SHOT = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [2:0]      shots_log2_i;
  logic            launch_o;
  logic [TAPS-1:0] taps_i;
  logic            busy_o;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [TAPW-1:0] res_avg_o;
  logic [SUMW-1:0] res_sum_o;
  logic            res_sat_o;
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
  logic [TAPW-1:0] res_min_o;
  logic [TAPW-1:0] res_max_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  logic launch_prev = 1'b0;

  delay_line_sweep_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .shots_log2_i (shots_log2_i),
    .launch_o     (launch_o),
    .taps_i       (taps_i),
    .busy_o       (busy_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_avg_o    (res_avg_o),
    .res_sum_o    (res_sum_o),
    .res_sat_o    (res_sat_o)
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
    ,
    .res_min_o    (res_min_o),
    .res_max_o    (res_max_o)
`endif
  );

  always #5 clk = ~clk;

  // Count rising edges of launch_o over the whole run.
  always @(posedge clk) begin
    launch_prev <= launch_o;
    if (launch_o && !launch_prev) pulses <= pulses + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas(input logic [2:0] n);
    start_i      = 1'b1;
    shots_log2_i = n;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (!res_valid_o && cyc < limit) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_valid_seen"}, {31'd0, res_valid_o}, 32'd1);
  endtask

  task automatic ack();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    check_eq("ack_valid_low", {31'd0, res_valid_o}, 32'd0);
    check_eq("ack_busy_low", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic run_simple(input string tag, input logic [2:0] n, input logic [31:0] taps,
                            input int exp_shots, input int exp_sum, input int exp_avg,
                            input int exp_sat);
    int lat;
    int p0;
    taps_i = taps;
    p0 = pulses;
    start_meas(n);
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    wait_valid(tag, exp_shots * SHOT + 20, lat);
    check_eq({tag, "_latency"}, lat, exp_shots * SHOT);
    check_eq({tag, "_sum"}, {22'd0, res_sum_o}, exp_sum);
    check_eq({tag, "_avg"}, {26'd0, res_avg_o}, exp_avg);
    check_eq({tag, "_sat"}, {31'd0, res_sat_o}, exp_sat);
    ack();
    check_eq({tag, "_pulses"}, pulses - p0, exp_shots);
    check_eq({tag, "_sum_hold"}, {22'd0, res_sum_o}, exp_sum);
  endtask

  logic [31:0] pats [4] = '{32'h0000_0007, 32'h0000_01FF, 32'h0000_001F, 32'h0000_007F};

  initial begin
    int lat;
    int k;
    int cyc;
    int p0;
    logic prev;

    rst          = 1'b1;
    start_i      = 1'b0;
    shots_log2_i = 3'd0;
    taps_i       = 32'h0;
    res_ready_i  = 1'b0;
    tick();
    tick();
    check_eq("rst_launch", {31'd0, launch_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_valid", {31'd0, res_valid_o}, 32'd0);
    check_eq("rst_sum", {22'd0, res_sum_o}, 32'd0);
    check_eq("rst_avg", {26'd0, res_avg_o}, 32'd0);
    check_eq("rst_sat", {31'd0, res_sat_o}, 32'd0);
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
    check_eq("rst_min", {26'd0, res_min_o}, 32'd0);
    check_eq("rst_max", {26'd0, res_max_o}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    run_simple("t1_ff", 3'd0, 32'h0000_00FF, 1, 8, 8, 0);
    run_simple("t2_0f", 3'd2, 32'h0000_000F, 4, 16, 4, 0);
    run_simple("t3_full", 3'd1, 32'hFFFF_FFFF, 2, 64, 32, 1);
    run_simple("t4_bubble", 3'd0, 32'h0000_00F7, 1, 3, 3, 0);
    run_simple("t4_zero", 3'd0, 32'h0000_0000, 1, 0, 0, 0);

    // Result held under back-pressure; start during DONE is ignored.
    taps_i = 32'h0000_00FF;
    start_meas(3'd0);
    wait_valid("t5", 30, lat);
    taps_i = 32'h0000_0003;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        start_i      = 1'b1;
        shots_log2_i = 3'd2;
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    start_i = 1'b0;
    check_eq("t5_valid_held", {31'd0, res_valid_o}, 32'd1);
    check_eq("t5_busy_held", {31'd0, busy_o}, 32'd1);
    check_eq("t5_sum_held", {22'd0, res_sum_o}, 32'd8);
    check_eq("t5_avg_held", {26'd0, res_avg_o}, 32'd8);
    ack();
    check_eq("t5_sum_after", {22'd0, res_sum_o}, 32'd8);
    run_simple("t5_restart", 3'd0, 32'h0000_0003, 1, 2, 2, 0);

    // Reset during CAPTURE aborts and drops the earlier result.
    taps_i = 32'h0000_00FF;
    start_meas(3'd0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("t6_launch_capture", {31'd0, launch_o}, 32'd1);
    rst = 1'b1;
    tick();
    check_eq("t6_launch", {31'd0, launch_o}, 32'd0);
    check_eq("t6_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t6_valid", {31'd0, res_valid_o}, 32'd0);
    check_eq("t6_sum_dropped", {22'd0, res_sum_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Per-shot counts 3,9,5,7, taps changed on each launch.
    taps_i = 32'h0;
    p0 = pulses;
    start_meas(3'd2);
    k = 0;
    cyc = 0;
    prev = launch_o;
    while (!res_valid_o && cyc < 60) begin
      if (launch_o && !prev && k < 4) begin
        taps_i = pats[k];
        k++;
      end
      prev = launch_o;
      tick();
      cyc++;
    end
    check_eq("t7_latency", cyc, 28);
    check_eq("t7_sum", {22'd0, res_sum_o}, 32'd24);
    check_eq("t7_avg", {26'd0, res_avg_o}, 32'd6);
`ifdef DELAY_LINE_SWEEP_MINMAX_EN
    check_eq("t7_min", {26'd0, res_min_o}, 32'd3);
    check_eq("t7_max", {26'd0, res_max_o}, 32'd9);
`endif
    ack();
    check_eq("t7_pulses", pulses - p0, 4);

    // shots_log2_i above MAXLOG clamps to 16 shots.
    run_simple("t8_clamp", 3'd7, 32'h0000_0001, 16, 16, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
